// File: rtl/enum_seq_multi.sv
// enum_seq_multi: NCH independent enum-typed state counters. Each channel can
// hold, count up, count down or ping-pong, and accepts a synchronous load.
// An illegal load sets a sticky error flag that only reset clears.
module enum_seq_multi #(
    parameter int NCH         = 2,
    parameter int NUM_STATES  = 3,
    parameter int RESET_STATE = 0,
    localparam int STATE_W    = $clog2(NUM_STATES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           en,
    input  logic [2*NCH-1:0]         mode,
    input  logic [NCH-1:0]           load,
    input  logic [NCH*STATE_W-1:0]   load_val,
    output logic [NCH*STATE_W-1:0]   state,
    output logic [NCH-1:0]           dir,
    output logic [NCH-1:0]           wrap,
    output logic                     err
);

    // Only the two endpoints are named; interior encodings are reached by casts.
    typedef enum logic [STATE_W-1:0] {
        S0     = {STATE_W{1'b0}},
        S_LAST = STATE_W'(NUM_STATES - 1)
    } state_t;

    typedef enum logic [1:0] {
        M_HOLD = 2'd0,
        M_UP   = 2'd1,
        M_DOWN = 2'd2,
        M_PING = 2'd3
    } mode_t;

    localparam logic [STATE_W-1:0] ONE      = STATE_W'(1);
    localparam logic [STATE_W-1:0] LAST_M1  = STATE_W'(NUM_STATES - 2);
    localparam logic [STATE_W:0]   LIMIT    = (STATE_W + 1)'(NUM_STATES);
    localparam state_t             RESET_ST = state_t'(STATE_W'(RESET_STATE));

    state_t               st_q   [NCH];
    state_t               prev_q [NCH];
    mode_t                ch_mode[NCH];
    logic [STATE_W-1:0]   ch_lv  [NCH];

    // Unpack the flat mode/load buses and repack the per-channel state.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign ch_mode[g] = mode_t'(mode[2*g +: 2]);
        assign ch_lv[g]   = load_val[g*STATE_W +: STATE_W];
        assign state[g*STATE_W +: STATE_W] = st_q[g];
    end

    // Per-channel update: load beats step beats hold; wrap is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]   <= RESET_ST;
                prev_q[i] <= RESET_ST;
            end
            dir  <= '0;
            wrap <= '0;
            err  <= 1'b0;
        end else begin
            wrap <= '0;
            for (int i = 0; i < NCH; i++) begin
                prev_q[i] <= st_q[i];
                if (load[i]) begin
                    if ({1'b0, ch_lv[i]} < LIMIT) begin
                        st_q[i] <= state_t'(ch_lv[i]);
                    end else begin
                        err <= 1'b1;
                    end
                end else if (en[i]) begin
                    case (ch_mode[i])
                        M_UP: begin
                            if (st_q[i] == S_LAST) begin
                                st_q[i] <= S0;
                                wrap[i] <= 1'b1;
                            end else begin
                                st_q[i] <= state_t'(st_q[i] + ONE);
                            end
                        end
                        M_DOWN: begin
                            if (st_q[i] == S0) begin
                                st_q[i] <= S_LAST;
                                wrap[i] <= 1'b1;
                            end else begin
                                st_q[i] <= state_t'(st_q[i] - ONE);
                            end
                        end
                        M_PING: begin
                            if (!dir[i]) begin
                                if (st_q[i] == S_LAST) begin
                                    st_q[i] <= state_t'(LAST_M1);
                                    dir[i]  <= 1'b1;
                                    wrap[i] <= 1'b1;
                                end else begin
                                    st_q[i] <= state_t'(st_q[i] + ONE);
                                end
                            end else begin
                                if (st_q[i] == S0) begin
                                    st_q[i] <= state_t'(ONE);
                                    dir[i]  <= 1'b0;
                                    wrap[i] <= 1'b1;
                                end else begin
                                    st_q[i] <= state_t'(st_q[i] - ONE);
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Structural invariants, checked only while out of reset.
    always @(*) begin
        if (rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                assert ({1'b0, st_q[i]} < LIMIT);
                if (wrap[i]) begin
                    assert (prev_q[i] == S0 || prev_q[i] == S_LAST);
                end
            end
            assert (S0 == {STATE_W{1'b0}});
            assert (state_t'(RESET_STATE) == RESET_ST);
        end
    end

endmodule

// File: tb/tb_enum_seq_multi.sv
// Directed bench for enum_seq_multi: a 2-channel/3-state instance carries the
// main sequence, a 4-channel/2-state instance with reset state 1 and a
// 1-channel/5-state instance cover the small and non-power-of-2 cases.
module tb_enum_seq_multi;

    localparam logic [1:0] M_HOLD = 2'd0;
    localparam logic [1:0] M_UP   = 2'd1;
    localparam logic [1:0] M_DOWN = 2'd2;
    localparam logic [1:0] M_PING = 2'd3;

    logic clk = 1'b0;
    logic rst_n;

    // Instance A: NCH=2, NUM_STATES=3, STATE_W=2
    logic [1:0] en_a, load_a, dir_a, wrap_a;
    logic [3:0] mode_a, lv_a;
    logic [3:0] state_a;
    logic       err_a;

    // Instance B: NCH=4, NUM_STATES=2, RESET_STATE=1, STATE_W=1
    logic [3:0] en_b, load_b, lv_b, state_b, dir_b, wrap_b;
    logic [7:0] mode_b;
    logic       err_b;

    // Instance C: NCH=1, NUM_STATES=5, STATE_W=3
    logic [0:0] en_c, load_c, dir_c, wrap_c;
    logic [1:0] mode_c;
    logic [2:0] lv_c, state_c;
    logic       err_c;

    int checks = 0;
    int errors = 0;

    enum_seq_multi #(.NCH(2), .NUM_STATES(3), .RESET_STATE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .load(load_a),
        .load_val(lv_a), .state(state_a), .dir(dir_a), .wrap(wrap_a), .err(err_a)
    );

    enum_seq_multi #(.NCH(4), .NUM_STATES(2), .RESET_STATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .load(load_b),
        .load_val(lv_b), .state(state_b), .dir(dir_b), .wrap(wrap_b), .err(err_b)
    );

    enum_seq_multi #(.NCH(1), .NUM_STATES(5), .RESET_STATE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode_c), .load(load_c),
        .load_val(lv_c), .state(state_c), .dir(dir_c), .wrap(wrap_c), .err(err_c)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive instance A inputs.
    task automatic applyStimulus(input logic [1:0] en, input logic [3:0] mode,
                                 input logic [1:0] load, input logic [3:0] lv);
        en_a   = en;
        mode_a = mode;
        load_a = load;
        lv_a   = lv;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ust[7]  = '{1, 2, 0, 1, 2, 0, 1};
    int uwr[7]  = '{0, 0, 1, 0, 0, 1, 0};
    int pst[8]  = '{1, 2, 1, 0, 1, 2, 1, 0};
    int pdir[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int pwr[8]  = '{0, 0, 1, 0, 1, 0, 1, 0};
    int dst[3]  = '{2, 1, 0};
    int dwr[3]  = '{1, 0, 0};
    int bst[3]  = '{4'b1110, 4'b1111, 4'b1110};
    int bdir[3] = '{1, 0, 1};

    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 4'b0000, 2'b00, 4'b0000);
        en_b = '0; mode_b = '0; load_b = '0; lv_b = '0;
        en_c = '0; mode_c = '0; load_c = '0; lv_c = '0;
        tick();
        tick();
        checkOutput("a_rst_state", int'(state_a), 0);
        checkOutput("a_rst_dir",   int'(dir_a), 0);
        checkOutput("a_rst_wrap",  int'(wrap_a), 0);
        checkOutput("a_rst_err",   int'(err_a), 0);
        checkOutput("b_rst_state", int'(state_b), 4'b1111);
        rst_n = 1'b1;

        // ch0 counts up, ch1 idle
        applyStimulus(2'b01, {M_HOLD, M_UP}, 2'b00, 4'b0000);
        for (int k = 0; k < 7; k++) begin
            tick();
            checkOutput($sformatf("up_st0_%0d", k), int'(state_a[1:0]), ust[k]);
            checkOutput($sformatf("up_wr0_%0d", k), int'(wrap_a[0]), uwr[k]);
            checkOutput($sformatf("up_st1_%0d", k), int'(state_a[3:2]), 0);
        end

        // ch1 ping-pong, ch0 idle at 1
        applyStimulus(2'b10, {M_PING, M_HOLD}, 2'b00, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("ping_st1_%0d", k),  int'(state_a[3:2]), pst[k]);
            checkOutput($sformatf("ping_dir1_%0d", k), int'(dir_a[1]), pdir[k]);
            checkOutput($sformatf("ping_wr1_%0d", k),  int'(wrap_a[1]), pwr[k]);
        end
        checkOutput("ping_st0_held", int'(state_a[1:0]), 1);

        // load ch0 to 0, then count down
        applyStimulus(2'b00, {M_PING, M_DOWN}, 2'b01, 4'b0000);
        tick();
        checkOutput("load0_st0", int'(state_a[1:0]), 0);
        applyStimulus(2'b01, {M_PING, M_DOWN}, 2'b00, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("down_st0_%0d", k), int'(state_a[1:0]), dst[k]);
            checkOutput($sformatf("down_wr0_%0d", k), int'(wrap_a[0]), dwr[k]);
        end
        // load beats enable on the same edge
        applyStimulus(2'b01, {M_PING, M_DOWN}, 2'b01, 4'b0001);
        tick();
        checkOutput("ldpri_st0", int'(state_a[1:0]), 1);
        checkOutput("ldpri_wr0", int'(wrap_a[0]), 0);
        checkOutput("ldpri_st1", int'(state_a[3:2]), 0);

        // illegal load: no change, no step, sticky err
        applyStimulus(2'b01, {M_PING, M_DOWN}, 2'b01, 4'b0011);
        tick();
        checkOutput("illegal_st0", int'(state_a[1:0]), 1);
        checkOutput("illegal_err", int'(err_a), 1);
        checkOutput("illegal_wr0", int'(wrap_a[0]), 0);
        applyStimulus(2'b00, {M_PING, M_DOWN}, 2'b00, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("err_hold_%0d", k), int'(err_a), 1);
        end
        applyStimulus(2'b00, {M_PING, M_DOWN}, 2'b01, 4'b0010);
        tick();
        checkOutput("legal_after_st0", int'(state_a[1:0]), 2);
        checkOutput("legal_after_err", int'(err_a), 1);
        checkOutput("pre_rst_dir1",    int'(dir_a[1]), 1);

        // asynchronous reset between edges
        applyStimulus(2'b00, {M_HOLD, M_UP}, 2'b00, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_state", int'(state_a), 0);
        checkOutput("async_dir",   int'(dir_a), 0);
        checkOutput("async_err",   int'(err_a), 0);
        #3;
        rst_n = 1'b1;
        applyStimulus(2'b01, {M_HOLD, M_UP}, 2'b00, 4'b0000);
        tick();
        checkOutput("resume_st0", int'(state_a[1:0]), 1);
        applyStimulus(2'b00, {M_HOLD, M_UP}, 2'b00, 4'b0000);

        // instance B: reset value 1, two-state ping-pong on ch0
        checkOutput("b_post_rst", int'(state_b), 4'b1111);
        en_b   = 4'b0001;
        mode_b = {M_HOLD, M_HOLD, M_HOLD, M_PING};
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("b_st_%0d", k),  int'(state_b), bst[k]);
            checkOutput($sformatf("b_wr_%0d", k),  int'(wrap_b), 1);
            checkOutput($sformatf("b_dir_%0d", k), int'(dir_b[0]), bdir[k]);
        end
        en_b = '0;

        // instance C: five-state up counter never leaves 0..4
        en_c   = 1'b1;
        mode_c = M_UP;
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput($sformatf("c_range_%0d", k), int'(state_c < 3'd5), 1);
            checkOutput($sformatf("c_st_%0d", k), int'(state_c), (k + 1) % 5);
            checkOutput($sformatf("c_wr_%0d", k), int'(wrap_c), ((k + 1) % 5 == 0) ? 1 : 0);
        end
        en_c = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
